// File: rtl/rx_pkg.sv
// Shared definitions for the receive stream controller.
//   rx_state_e   : controller FSM states (ACCEPT, DISCARD)
//   RX_DATA_W    : default received byte width
//   RX_ERR_CNT_W : default error counter width
package rx_pkg;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } rx_state_e;

  localparam int RX_DATA_W    = 8;
  localparam int RX_ERR_CNT_W = 8;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO holding received bytes for the downstream consumer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and byte
//   i_pop          : remove head (ignored while empty)
//   i_flush        : empty the FIFO; overrides push and pop in the same cycle
//   o_data         : head entry (0 while empty)
//   o_valid        : FIFO non-empty
//   o_full         : FIFO holds DEPTH entries
//   o_fill         : current entry count, 0..DEPTH
module rx_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~w_empty;
  // A push into a full FIFO is still legal when the head leaves in the same
  // cycle; the write lands in the slot being vacated.
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage carries no reset: an entry is only observable once counted.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Masking with empty keeps the head at 0 after reset or flush.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_full  = w_full;
  assign o_fill  = r_count;

endmodule

// File: rtl/rx_stream_ctrl.sv
// Receive-side stream controller behind the UART receiver. Good bytes are
// buffered for a valid/ready consumer; a parity error drops the byte and
// discards all traffic until the line has been quiet for GAP_CYCLES clocks.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   received_data    : byte from receiver, qualified by data_is_valid
//   data_is_valid    : one-cycle pulse per received byte
//   rx_error         : parity verdict for the pulsed byte (1 = bad)
//   flush            : empty the FIFO (status and FSM untouched)
//   clear_status     : clear sticky flags and error counter
//   out_data/out_valid/out_ready : consumer stream
//   fill_level       : FIFO entry count
//   overrun          : sticky, good byte lost to a full FIFO
//   parity_err       : sticky, byte arrived with rx_error=1
//   err_count        : saturating count of overruns plus parity errors
//   discarding       : controller is in DISCARD
module rx_stream_ctrl
  import rx_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = RX_DATA_W,
  parameter int FIFO_DEPTH       = 16,
  parameter int GAP_CYCLES       = 1024,
  parameter int ERR_CNT_WIDTH    = RX_ERR_CNT_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [INPUT_DATA_WIDTH-1:0]     received_data,
  input  logic                            data_is_valid,
  input  logic                            rx_error,
  input  logic                            flush,
  input  logic                            clear_status,
  output logic [INPUT_DATA_WIDTH-1:0]     out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            overrun,
  output logic                            parity_err,
  output logic [ERR_CNT_WIDTH-1:0]        err_count,
  output logic                            discarding
);

  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
    input logic [ERR_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  rx_state_e                r_state;
  logic [GAP_W-1:0]         r_gap;
  logic                     r_discarding;
  logic                     r_overrun;
  logic                     r_parity_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic w_fifo_valid;
  logic w_fifo_full;
  logic w_good;
  logic w_push;
  logic w_ovr_evt;
  logic w_par_evt;
  logic w_err_evt;

  assign w_good    = data_is_valid & ~rx_error & (r_state == ST_ACCEPT);
  assign w_push    = w_good & ~flush;
  // A flushed push is dropped silently; only a genuine full-FIFO loss counts.
  assign w_ovr_evt = w_push & w_fifo_full & ~(w_fifo_valid & out_ready);
  assign w_par_evt = data_is_valid & rx_error;
  assign w_err_evt = w_ovr_evt | w_par_evt;

  rx_sync_fifo #(
    .DATA_W (INPUT_DATA_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (received_data),
    .i_pop   (out_ready),
    .i_flush (flush),
    .o_data  (out_data),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full),
    .o_fill  (fill_level)
  );

  // Any byte pulse restarts the quiet-gap measurement; only an uninterrupted
  // run of GAP_CYCLES idle clocks returns the controller to ACCEPT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ACCEPT;
      r_gap        <= '0;
      r_discarding <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_par_evt) begin
            r_state      <= ST_DISCARD;
            r_gap        <= '0;
            r_discarding <= 1'b1;
          end
        end
        ST_DISCARD: begin
          if (data_is_valid) begin
            r_gap <= '0;
          end else if (r_gap == GAP_LAST) begin
            r_state      <= ST_ACCEPT;
            r_gap        <= '0;
            r_discarding <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_ACCEPT;
          r_gap        <= '0;
          r_discarding <= 1'b0;
        end
      endcase
    end
  end

  // An error arriving together with clear_status survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_count  <= '0;
    end else if (clear_status) begin
      r_overrun    <= w_ovr_evt;
      r_parity_err <= w_par_evt;
      r_err_count  <= w_err_evt ? ERR_CNT_WIDTH'(1) : '0;
    end else begin
      r_overrun    <= r_overrun | w_ovr_evt;
      r_parity_err <= r_parity_err | w_par_evt;
      if (w_err_evt) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign out_valid  = w_fifo_valid;
  assign overrun    = r_overrun;
  assign parity_err = r_parity_err;
  assign err_count  = r_err_count;
  assign discarding = r_discarding;

endmodule

// File: tb/tb_rx_stream_ctrl.sv
module tb_rx_stream_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int GAP   = 8;
  localparam int CW    = 8;

  logic          clk;
  logic          reset;
  logic [DW-1:0] received_data;
  logic          data_is_valid;
  logic          rx_error;
  logic          flush;
  logic          clear_status;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    fill_level;
  logic          overrun;
  logic          parity_err;
  logic [CW-1:0] err_count;
  logic          discarding;

  int n_pass;
  int n_total;

  rx_stream_ctrl #(
    .INPUT_DATA_WIDTH (DW),
    .FIFO_DEPTH       (DEPTH),
    .GAP_CYCLES       (GAP),
    .ERR_CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .received_data (received_data),
    .data_is_valid (data_is_valid),
    .rx_error      (rx_error),
    .flush         (flush),
    .clear_status  (clear_status),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fill_level    (fill_level),
    .overrun       (overrun),
    .parity_err    (parity_err),
    .err_count     (err_count),
    .discarding    (discarding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          err;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    int            e_fill;
    logic          e_par;
    int            e_cnt;
    logic          e_disc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic err);
    received_data = d;
    data_is_valid = 1'b1;
    rx_error      = err;
    step();
    data_is_valid = 1'b0;
    rx_error      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"},  int'(out_data), 0);
    chk({tag, "_fill"},  int'(fill_level), 0);
    chk({tag, "_ovr"},   int'(overrun), 0);
    chk({tag, "_par"},   int'(parity_err), 0);
    chk({tag, "_cnt"},   int'(err_count), 0);
    chk({tag, "_disc"},  int'(discarding), 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; received_data = '0; data_is_valid = 1'b0; rx_error = 1'b0;
    flush = 1'b0; clear_status = 1'b0; out_ready = 1'b0;

    //            v  err  d      rdy  valid data   fill par cnt disc
    vecs[0] = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h42, 1'b1, 1'b1, 8'h42, 1, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h43, 1'b1, 1'b1, 8'h43, 1, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 8'h77, 1, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h78, 1'b0, 1'b1, 8'h77, 2, 1'b0, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h78, 1, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0, 1'b0};

    #12;
    chk_reset_state("in_reset");
    reset = 1'b1;
    step();
    chk_reset_state("after_reset");

    // Table: basic streaming, stall and drain
    for (int i = 0; i < 8; i++) begin
      received_data = vecs[i].d;
      data_is_valid = vecs[i].v;
      rx_error      = vecs[i].err;
      out_ready     = vecs[i].rdy;
      step();
      data_is_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i),  int'(out_data),  int'(vecs[i].e_data));
      chk($sformatf("vec%0d_fill", i),  int'(fill_level), vecs[i].e_fill);
      chk($sformatf("vec%0d_par", i),   int'(parity_err), int'(vecs[i].e_par));
      chk($sformatf("vec%0d_cnt", i),   int'(err_count), vecs[i].e_cnt);
      chk($sformatf("vec%0d_disc", i),  int'(discarding), int'(vecs[i].e_disc));
    end

    // Overrun: 17 bytes into 16 entries
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) pulse(8'(8'h20 + i), 1'b0);
    chk("ovr_fill", int'(fill_level), 16);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_cnt",  int'(err_count), 1);
    chk("ovr_head", int'(out_data), 8'h20);
    // Simultaneous push and pop while full
    out_ready = 1'b1;
    pulse(8'hAA, 1'b0);
    out_ready = 1'b0;
    chk("pp_fill", int'(fill_level), 16);
    chk("pp_cnt",  int'(err_count), 1);
    chk("pp_head", int'(out_data), 8'h21);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), int'(out_data), (k < 15) ? (8'h21 + k) : 8'hAA);
      step();
    end
    chk("drain_empty", int'(out_valid), 0);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("clr_ovr", int'(overrun), 0);
    chk("clr_cnt", int'(err_count), 0);

    // Parity error and gap resync
    out_ready = 1'b0;
    pulse(8'h55, 1'b1);
    chk("par_flag", int'(parity_err), 1);
    chk("par_disc", int'(discarding), 1);
    chk("par_drop", int'(out_valid), 0);
    chk("par_cnt",  int'(err_count), 1);
    idle(2);
    pulse(8'h10, 1'b0);
    idle(GAP - 2);
    pulse(8'h11, 1'b0);
    chk("gap_drop", int'(fill_level), 0);
    chk("gap_cnt",  int'(err_count), 1);
    idle(GAP - 1);
    chk("gap_still_disc", int'(discarding), 1);
    step();
    chk("gap_exit", int'(discarding), 0);
    pulse(8'h66, 1'b0);
    chk("resync_valid", int'(out_valid), 1);
    chk("resync_data",  int'(out_data), 8'h66);
    chk("resync_fill",  int'(fill_level), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("resync_pop", int'(out_valid), 0);

    // Error counter saturation and clear-vs-error priority
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    for (int i = 0; i < 255; i++) pulse(8'hE0, 1'b1);
    chk("sat_255", int'(err_count), 255);
    pulse(8'hE1, 1'b1);
    chk("sat_hold", int'(err_count), 255);
    clear_status = 1'b1;
    pulse(8'hE2, 1'b1);
    clear_status = 1'b0;
    chk("clr_win_par", int'(parity_err), 1);
    chk("clr_win_cnt", int'(err_count), 1);
    idle(GAP + 1);
    chk("sat_exit", int'(discarding), 0);

    // Flush coinciding with a push
    for (int i = 0; i < 5; i++) pulse(8'(8'h30 + i), 1'b0);
    chk("fl_pre_fill", int'(fill_level), 5);
    flush = 1'b1;
    pulse(8'h35, 1'b0);
    flush = 1'b0;
    chk("fl_fill",  int'(fill_level), 0);
    chk("fl_valid", int'(out_valid), 0);
    chk("fl_ovr",   int'(overrun), 0);
    chk("fl_cnt",   int'(err_count), 1);
    pulse(8'h99, 1'b0);
    chk("fl_post_data", int'(out_data), 8'h99);
    chk("fl_post_fill", int'(fill_level), 1);

    // Reset while discarding with 3 bytes buffered
    pulse(8'h9A, 1'b0);
    pulse(8'h9B, 1'b0);
    pulse(8'hBD, 1'b1);
    chk("rst_pre_fill", int'(fill_level), 3);
    chk("rst_pre_disc", int'(discarding), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async_rst");
    step();
    reset = 1'b1;
    step();
    chk_reset_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_stream_ctrl.md
# rx_stream_ctrl

Receive-side stream controller that sits directly behind the UART receive top level. It accepts each received byte pulse together with its parity verdict and buffers good bytes in a FIFO for a valid/ready consumer. It drops corrupted bytes and resynchronises after a parity error by discarding traffic until the line has been quiet for a programmable gap. Sticky status flags and a saturating error counter are exposed for software.

## Interface
Parameters:
- INPUT_DATA_WIDTH, 8, byte width; matches the receiver.
- FIFO_DEPTH, 16, buffer entries; power of two, ≥2.
- GAP_CYCLES, 1024, idle clocks with no byte pulse required to leave DISCARD; ≥2.
- ERR_CNT_WIDTH, 8, error counter width.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- received_data  in  INPUT_DATA_WIDTH  byte from receiver; sampled only when data_is_valid=1.
- data_is_valid  in  1  one-cycle pulse per received byte.
- rx_error  in  1  parity verdict; sampled in the same cycle as data_is_valid; 1 = bad byte.
- flush  in  1  synchronous FIFO empty request.
- clear_status  in  1  clears sticky flags and error counter.
- out_data  out  INPUT_DATA_WIDTH  head of FIFO.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid=1.
- fill_level  out  log2(FIFO_DEPTH)+1  current entry count.
- overrun  out  1  sticky; a good byte was dropped because the FIFO was full.
- parity_err  out  1  sticky; a byte arrived with rx_error=1.
- err_count  out  ERR_CNT_WIDTH  saturating count of overruns plus parity errors.
- discarding  out  1  FSM is in DISCARD.

## Operation
- FSM states: ACCEPT (reset state) and DISCARD.
- ACCEPT, data_is_valid & !rx_error: push the byte. If the FIFO is full and no pop occurs in the same cycle, drop the byte, set overrun, and increment err_count.
- ACCEPT, data_is_valid & rx_error: drop the byte, set parity_err, increment err_count, clear the gap counter, and go to DISCARD.
- DISCARD: every data_is_valid drops its byte and clears the gap counter. If rx_error is also 1, set parity_err and increment err_count. Otherwise the gap counter increments each clock. When it reaches GAP_CYCLES-1, go to ACCEPT.
- Pop: out_valid & out_ready removes the head.
- Simultaneous push and pop while full: both take effect; no overrun; fill_level unchanged.
- Pop while empty is ignored.
- flush: sets fill_level to 0 and pointers to 0. A push in the same cycle is discarded without flags. FSM, flags and counter are unaffected.
- clear_status: clears overrun, parity_err and err_count. A new error in the same cycle wins: the flag ends at 1 and err_count ends at 1.
- err_count saturates at all ones. Two error sources never coincide, because there is one byte per pulse.
- Pointers wrap modulo FIFO_DEPTH. fill_level ranges 0..FIFO_DEPTH.

## Timing
- Reset values: out_data=0, out_valid=0, fill_level=0, overrun=0, parity_err=0, err_count=0, discarding=0. FSM is ACCEPT, gap counter 0.
- Push latency: a byte pulsed in cycle N appears on out_data/out_valid in cycle N+1 when the FIFO was empty.
- Flags, err_count, fill_level and discarding are registered and update one cycle after the causing event.
- out_data is stable while out_valid=1 and out_ready=0.
- The DISCARD→ACCEPT exit occurs exactly GAP_CYCLES clocks after the last byte pulse. A pulse in the exit cycle is handled under ACCEPT rules in the following cycle only.
- Reset asserted mid-operation clears everything immediately, including FIFO contents.

## Structure
- Shared package rx_pkg: FSM state typedef (ACCEPT, DISCARD) and default width constants (INPUT_DATA_WIDTH=8, ERR_CNT_WIDTH=8).
- One sub-module, rx_sync_fifo: parameterised storage, read/write pointers, fill count, flush.
- The FSM, gap counter, flags and err_count live in rx_stream_ctrl.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with out_ready=1 → out_data sequence 0x41, 0x42, 0x43, each one cycle after its pulse; flags 0; err_count 0.
- out_ready=0, push 17 bytes with FIFO_DEPTH=16 → fill_level=16, overrun=1, err_count=1, byte 17 absent. Then push and pop in the same cycle while full → no further overrun.
- Byte 0x55 with rx_error=1 → parity_err=1, discarding=1, byte dropped. Bytes 0x10, 0x11 inside the gap are dropped. A byte arriving GAP_CYCLES+1 clocks after 0x11 is delivered.
- err_count preloaded to 0xFF via 255 parity errors, then one more → remains 0xFF. clear_status in the same cycle as a parity error → parity_err=1, err_count=1.
- FIFO holds 5 bytes and flush coincides with a push → fill_level=0, out_valid=0, overrun=0.
- Assert reset while in DISCARD with 3 bytes buffered → all outputs return to their reset values on the reset edge.
